// File: rtl/voxel_dda_stepper.sv
// Amanatides-Woo 3D DDA stepper for a 32x32x32 occupancy grid: walks one ray
// voxel by voxel and reports hit, step-limit timeout or grid exit.
module voxel_dda_stepper #(
    parameter int unsigned  T_W       = 16,
    parameter int unsigned  MAX_STEPS = 96,
    localparam int unsigned S_W       = $clog2(MAX_STEPS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [4:0]     start_x,
    input  logic [4:0]     start_y,
    input  logic [4:0]     start_z,
    input  logic           step_x_neg,
    input  logic           step_y_neg,
    input  logic           step_z_neg,
    input  logic [T_W-1:0] tmax_x,
    input  logic [T_W-1:0] tmax_y,
    input  logic [T_W-1:0] tmax_z,
    input  logic [T_W-1:0] tdelta_x,
    input  logic [T_W-1:0] tdelta_y,
    input  logic [T_W-1:0] tdelta_z,
    output logic [4:0]     vox_x,
    output logic [4:0]     vox_y,
    output logic [4:0]     vox_z,
    output logic           mem_rd_en,
    input  logic           occ_rdata,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           res_hit,
    output logic           res_timeout,
    output logic [4:0]     res_x,
    output logic [4:0]     res_y,
    output logic [4:0]     res_z,
    output logic [S_W-1:0] res_steps
);

    typedef enum logic [1:0] {IDLE, READ, CHECK, DONE} state_e;

    state_e         state_q;
    logic [S_W-1:0] cnt_q;
    logic           neg_x_q, neg_y_q, neg_z_q;
    logic [T_W-1:0] tmax_x_q, tmax_y_q, tmax_z_q;
    logic [T_W-1:0] tdelta_x_q, tdelta_y_q, tdelta_z_q;
    logic [T_W-1:0] tmax_x_d, tmax_y_d, tmax_z_d;
    logic [4:0]     vox_x_d, vox_y_d, vox_z_d;
    logic           sel_x, sel_y, sel_z;
    logic           at_edge, at_limit;

    function automatic logic [T_W-1:0] sat_add(input logic [T_W-1:0] a, input logic [T_W-1:0] b);
        logic [T_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[T_W] ? {T_W{1'b1}} : s[T_W-1:0];
    endfunction

    // Smallest tMax wins; ties favour X, then Y, then Z.
    always_comb begin
        sel_x = (tmax_x_q <= tmax_y_q) && (tmax_x_q <= tmax_z_q);
        sel_y = !sel_x && (tmax_y_q <= tmax_z_q);
        sel_z = !sel_x && !sel_y;

        at_edge = (sel_x && (neg_x_q ? (vox_x == 5'd0) : (vox_x == 5'd31)))
               || (sel_y && (neg_y_q ? (vox_y == 5'd0) : (vox_y == 5'd31)))
               || (sel_z && (neg_z_q ? (vox_z == 5'd0) : (vox_z == 5'd31)));
        at_limit = (cnt_q == S_W'(MAX_STEPS));

        vox_x_d  = vox_x;
        vox_y_d  = vox_y;
        vox_z_d  = vox_z;
        tmax_x_d = tmax_x_q;
        tmax_y_d = tmax_y_q;
        tmax_z_d = tmax_z_q;
        if (sel_x) begin
            vox_x_d  = neg_x_q ? (vox_x - 5'd1) : (vox_x + 5'd1);
            tmax_x_d = sat_add(tmax_x_q, tdelta_x_q);
        end
        if (sel_y) begin
            vox_y_d  = neg_y_q ? (vox_y - 5'd1) : (vox_y + 5'd1);
            tmax_y_d = sat_add(tmax_y_q, tdelta_y_q);
        end
        if (sel_z) begin
            vox_z_d  = neg_z_q ? (vox_z - 5'd1) : (vox_z + 5'd1);
            tmax_z_d = sat_add(tmax_z_q, tdelta_z_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            start_ready <= 1'b1;
            mem_rd_en   <= 1'b0;
            res_valid   <= 1'b0;
            res_hit     <= 1'b0;
            res_timeout <= 1'b0;
            res_x       <= 5'd0;
            res_y       <= 5'd0;
            res_z       <= 5'd0;
            res_steps   <= '0;
            vox_x       <= 5'd0;
            vox_y       <= 5'd0;
            vox_z       <= 5'd0;
            cnt_q       <= '0;
            neg_x_q     <= 1'b0;
            neg_y_q     <= 1'b0;
            neg_z_q     <= 1'b0;
            tmax_x_q    <= '0;
            tmax_y_q    <= '0;
            tmax_z_q    <= '0;
            tdelta_x_q  <= '0;
            tdelta_y_q  <= '0;
            tdelta_z_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        vox_x       <= start_x;
                        vox_y       <= start_y;
                        vox_z       <= start_z;
                        neg_x_q     <= step_x_neg;
                        neg_y_q     <= step_y_neg;
                        neg_z_q     <= step_z_neg;
                        tmax_x_q    <= tmax_x;
                        tmax_y_q    <= tmax_y;
                        tmax_z_q    <= tmax_z;
                        tdelta_x_q  <= tdelta_x;
                        tdelta_y_q  <= tdelta_y;
                        tdelta_z_q  <= tdelta_z;
                        cnt_q       <= '0;
                        start_ready <= 1'b0;
                        mem_rd_en   <= 1'b1;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    mem_rd_en <= 1'b0;
                    cnt_q     <= cnt_q + S_W'(1);
                    state_q   <= CHECK;
                end
                CHECK: begin
                    if (occ_rdata || at_limit || at_edge) begin
                        res_valid   <= 1'b1;
                        res_hit     <= occ_rdata;
                        res_timeout <= !occ_rdata && at_limit;
                        res_x       <= vox_x;
                        res_y       <= vox_y;
                        res_z       <= vox_z;
                        res_steps   <= cnt_q;
                        state_q     <= DONE;
                    end else begin
                        vox_x     <= vox_x_d;
                        vox_y     <= vox_y_d;
                        vox_z     <= vox_z_d;
                        tmax_x_q  <= tmax_x_d;
                        tmax_y_q  <= tmax_y_d;
                        tmax_z_q  <= tmax_z_d;
                        mem_rd_en <= 1'b1;
                        state_q   <= READ;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voxel_dda_stepper.sv
// Scoreboard bench for voxel_dda_stepper: a plain-arithmetic ray walker
// predicts the read trace and result of every ray.
module tb_voxel_dda_stepper;
    localparam int unsigned TW = 16;
    localparam int unsigned MS = 20;
    localparam int unsigned SW = $clog2(MS + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_valid, start_ready;
    logic [4:0] start_x, start_y, start_z;
    logic step_x_neg, step_y_neg, step_z_neg;
    logic [TW-1:0] tmax_x, tmax_y, tmax_z, tdelta_x, tdelta_y, tdelta_z;
    logic [4:0] vox_x, vox_y, vox_z;
    logic mem_rd_en, occ_rdata, res_valid, res_ready, res_hit, res_timeout;
    logic [4:0] res_x, res_y, res_z;
    logic [SW-1:0] res_steps;

    voxel_dda_stepper #(.T_W(TW), .MAX_STEPS(MS)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_x(start_x), .start_y(start_y), .start_z(start_z),
        .step_x_neg(step_x_neg), .step_y_neg(step_y_neg), .step_z_neg(step_z_neg),
        .tmax_x(tmax_x), .tmax_y(tmax_y), .tmax_z(tmax_z),
        .tdelta_x(tdelta_x), .tdelta_y(tdelta_y), .tdelta_z(tdelta_z),
        .vox_x(vox_x), .vox_y(vox_y), .vox_z(vox_z),
        .mem_rd_en(mem_rd_en), .occ_rdata(occ_rdata),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_hit(res_hit), .res_timeout(res_timeout),
        .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_steps(res_steps)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sx, sy, sz;
        bit nx, ny, nz;
        int tmx, tmy, tmz, tdx, tdy, tdz;
    } ray_t;
    typedef struct {
        bit hit, to;
        int x, y, z, steps;
    } res_t;

    res_t   expq[$];
    int     rdq[$];
    bit     occ [32][32][32];
    int     checks = 0;
    int     passed = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    bit     hold_low = 1'b0;
    bit     was_valid = 1'b0, have_last = 1'b0, pend_rst = 1'b0;
    longint snap = 0, last = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
    endtask

    function automatic longint pack(input int hit, input int to, input int x, input int y,
                                    input int z, input int steps);
        return (longint'(hit) << 40) | (longint'(to) << 32) | (longint'(x) << 24)
             | (longint'(y) << 16) | (longint'(z) << 8) | longint'(steps);
    endfunction

    function automatic ray_t mk(input int sx, input int sy, input int sz,
                                input bit nx, input bit ny, input bit nz,
                                input int tmx, input int tmy, input int tmz,
                                input int tdx, input int tdy, input int tdz);
        ray_t r;
        r.sx = sx; r.sy = sy; r.sz = sz;
        r.nx = nx; r.ny = ny; r.nz = nz;
        r.tmx = tmx; r.tmy = tmy; r.tmz = tmz;
        r.tdx = tdx; r.tdy = tdy; r.tdz = tdz;
        return r;
    endfunction

    // Reference walk: visit, test, then advance the axis with the smallest tMax.
    task automatic model(input ray_t r);
        int p[3], tm[3], td[3], a, s;
        bit ng[3];
        res_t e;
        p  = '{r.sx, r.sy, r.sz};
        tm = '{r.tmx, r.tmy, r.tmz};
        td = '{r.tdx, r.tdy, r.tdz};
        ng = '{r.nx, r.ny, r.nz};
        e.hit = 0; e.to = 0;
        s = 0;
        forever begin
            s++;
            rdq.push_back(p[0] * 1024 + p[1] * 32 + p[2]);
            if (occ[p[0]][p[1]][p[2]]) begin e.hit = 1; break; end
            if (s == int'(MS)) begin e.to = 1; break; end
            a = 0;
            if (tm[1] < tm[a]) a = 1;
            if (tm[2] < tm[a]) a = 2;
            if (ng[a] ? (p[a] == 0) : (p[a] == 31)) break;
            p[a] = ng[a] ? p[a] - 1 : p[a] + 1;
            tm[a] = (tm[a] + td[a] > 65535) ? 65535 : tm[a] + td[a];
        end
        e.x = p[0]; e.y = p[1]; e.z = p[2]; e.steps = s;
        expq.push_back(e);
    endtask

    task automatic fill_grid(input int permille);
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++)
                for (int z = 0; z < 32; z++)
                    occ[x][y][z] = ($urandom_range(0, 999) < permille);
    endtask

    task automatic issue(input ray_t r);
        @(negedge clk);
        model(r);
        start_x = 5'(r.sx); start_y = 5'(r.sy); start_z = 5'(r.sz);
        step_x_neg = r.nx; step_y_neg = r.ny; step_z_neg = r.nz;
        tmax_x = TW'(r.tmx); tmax_y = TW'(r.tmy); tmax_z = TW'(r.tmz);
        tdelta_x = TW'(r.tdx); tdelta_y = TW'(r.tdy); tdelta_z = TW'(r.tdz);
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(expq.size() == 0 && rdq.size() == 0 && start_ready) && n < 4000);
        if (n >= 4000) fail("idle_wait");
    endtask

    // Occupancy RAM: data one cycle after the strobe, noise otherwise.
    always @(posedge clk)
        occ_rdata <= mem_rd_en ? occ[vox_x][vox_y][vox_z] : 1'($urandom);

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && start_valid && start_ready) acc_cyc = cyc;
    end

    // Monitor: read trace, result handshake, hold and persistence.
    always @(negedge clk) begin
        longint cur;
        res_t e;
        if (!rst_n) begin
            expq.delete();
            rdq.delete();
            was_valid = 1'b0;
            have_last = 1'b0;
            pend_rst  = 1'b1;
            res_ready = 1'b0;
        end else begin
            if (pend_rst) begin last = 0; have_last = 1'b1; pend_rst = 1'b0; end
            res_ready = hold_low ? 1'b0 : ($urandom_range(0, 2) == 0);
            cur = pack(int'(res_hit), int'(res_timeout), int'(res_x), int'(res_y),
                       int'(res_z), int'(res_steps));
            if (mem_rd_en) begin
                if (rdq.size() == 0) fail("unexpected_read");
                else chk("read_voxel", longint'({vox_x, vox_y, vox_z}), longint'(rdq.pop_front()));
            end
            if (res_valid) begin
                chk("start_ready_in_done", longint'(start_ready), 0);
                if (!was_valid) begin
                    snap = cur;
                    if (expq.size() == 0) fail("unexpected_result");
                    else chk("latency", longint'(cyc - acc_cyc), longint'(2 * expq[0].steps));
                end else begin
                    chk("result_hold", cur, snap);
                end
                if (res_ready && expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("result", cur, pack(int'(e.hit), int'(e.to), e.x, e.y, e.z, e.steps));
                    last = cur;
                    have_last = 1'b1;
                end
            end else if (have_last) begin
                chk("result_persist", cur, last);
            end
            was_valid = res_valid;
        end
    end

    initial begin
        ray_t r;
        int n, nr;
        start_valid = 1'b0;
        start_x = '0; start_y = '0; start_z = '0;
        step_x_neg = 1'b0; step_y_neg = 1'b0; step_z_neg = 1'b0;
        tmax_x = '0; tmax_y = '0; tmax_z = '0;
        tdelta_x = '0; tdelta_y = '0; tdelta_z = '0;
        res_ready = 1'b0;
        fill_grid(0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_start_ready", longint'(start_ready), 1);
        chk("reset_ctrl", longint'({mem_rd_en, res_valid, res_hit, res_timeout}), 0);
        chk("reset_vox", longint'({vox_x, vox_y, vox_z}), 0);
        chk("reset_res", longint'({res_x, res_y, res_z, res_steps}), 0);

        // Immediate hit
        occ[5][5][5] = 1'b1;
        issue(mk(5, 5, 5, 0, 0, 0, 3, 4, 5, 1, 1, 1));
        wait_idle();
        // X-axis walk to grid exit
        fill_grid(0);
        issue(mk(29, 0, 0, 0, 0, 0, 0, 65535, 65535, 1, 0, 0));
        wait_idle();
        // Tie-break with negative steps
        occ[9][9][9] = 1'b1;
        issue(mk(10, 10, 10, 1, 1, 1, 4, 4, 4, 8, 8, 8));
        wait_idle();
        // Step-limit timeout along +z
        fill_grid(0);
        issue(mk(0, 0, 0, 0, 0, 0, 65535, 65535, 0, 0, 0, 1));
        wait_idle();
        // tMax saturation: a wrapped X would be picked again immediately
        issue(mk(0, 0, 0, 0, 0, 0, 'hFFF0, 'hFFF8, 'hFFFF, 'h0020, 1, 0));
        wait_idle();

        // Result hold with res_ready low and a start offered during DONE
        occ[3][4][5] = 1'b1;
        hold_low = 1'b1;
        issue(mk(3, 4, 5, 1, 0, 1, 7, 7, 7, 2, 2, 2));
        n = 0;
        while (!res_valid && n < 100) begin @(negedge clk); n++; end
        if (!res_valid) fail("hold_wait");
        start_valid = 1'b1;
        start_x = 5'd1; start_y = 5'd2; start_z = 5'd3;
        repeat (10) @(negedge clk);
        chk("valid_held", longint'(res_valid), 1);
        start_valid = 1'b0;
        hold_low = 1'b0;
        wait_idle();

        // Reset during CHECK discards the ray
        fill_grid(0);
        issue(mk(0, 7, 7, 0, 0, 0, 0, 65535, 65535, 1, 0, 0));
        n = 0; nr = 0;
        while (nr < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (mem_rd_en) nr++;
        end
        if (nr < 3) fail("reads_before_reset");
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_mid_start_ready", longint'(start_ready), 1);
        chk("rst_mid_rd_en", longint'(mem_rd_en), 0);
        chk("rst_mid_valid", longint'(res_valid), 0);
        repeat (30) @(negedge clk);
        chk("rst_mid_no_result", longint'(res_valid), 0);

        // Randomized rays over grids of varying density
        for (int i = 0; i < 150; i++) begin
            wait_idle();
            if (i % 10 == 0) fill_grid(int'($urandom_range(0, 60)));
            r = mk(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
            if (i % 6 == 0) begin
                r.tmx = int'($urandom_range(65400, 65535));
                r.tdx = int'($urandom_range(0, 65535));
                r.tmy = int'($urandom_range(65400, 65535));
            end
            issue(r);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
